s3g_packet_rx: RTL and testbench

- Byte-level receiver/deframer for the S3G host protocol.
- Sits between the UART receiver (one byte plus a one-cycle strobe) and the command executor.
- Parses the frame: start byte 0xD5, length byte, payload, CRC-8 byte.
- Exposes the payload as 16 parallel byte registers and reports a one-cycle done or error pulse per frame.

---
 rtl/s3g_pkg.sv | 13 +
 rtl/s3g_packet_rx_if.sv | 25 ++
 rtl/s3g_crc8.sv | 16 +
 rtl/s3g_packet_rx.sv | 106 ++++++++++
 tb/tb_s3g_packet_rx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/s3g_pkg.sv
// Shared S3G framing constants and FSM state encoding, common to the RX deframer and TX framer.
package s3g_pkg;
  localparam logic [7:0] START_BYTE  = 8'hD5;
  localparam int         MAX_PAYLOAD = 16;
  localparam logic [7:0] CRC_POLY    = 8'h8C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CRC     = 2'd3
  } s3g_state_e;
endpackage

// File: rtl/s3g_packet_rx_if.sv
// Byte-strobe input and deframed payload outputs of the S3G receiver.
interface s3g_packet_rx_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       packet_done;
  logic       packet_error;
  logic [7:0] payload_len;
  logic       buffer_valid;
  logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
  logic [7:0] buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15;

  modport master (
    output rx_data, rx_done,
    input  packet_done, packet_error, payload_len, buffer_valid,
    input  buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
    input  buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15
  );

  modport slave (
    input  rx_data, rx_done,
    output packet_done, packet_error, payload_len, buffer_valid,
    output buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
    output buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15
  );
endinterface

// File: rtl/s3g_crc8.sv
// One-byte reflected CRC-8 (Maxim) update; purely combinational, zero latency.
// No backpressure: output follows inputs in the same cycle.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
    end
  end
endmodule

// File: rtl/s3g_packet_rx.sv
// S3G frame deframer: START, LEN, payload, CRC-8; done/error pulse one cycle after the final byte.
// No backpressure: every rx_done strobe is consumed; a stalled frame waits indefinitely.
module s3g_packet_rx
  import s3g_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  s3g_packet_rx_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_LEN     = LEN;
  localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
  localparam logic [1:0] ST_CRC     = CRC;

  logic [1:0] state;
  logic [3:0] idx;
  logic [7:0] crc;
  logic [7:0] crc_next;
  logic [7:0] len_q;
  logic       done_q;
  logic       error_q;
  logic       valid_q;
  logic [7:0] buf_q [MAX_PAYLOAD];

  s3g_crc8 u_crc8 (
    .crc_in  (crc),
    .data    (bus.rx_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      crc     <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < MAX_PAYLOAD; i++) buf_q[i] <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.rx_done) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == START_BYTE) begin
              state   <= ST_LEN;
              valid_q <= 1'b0;
            end
          end
          ST_LEN: begin
            len_q <= bus.rx_data;
            crc   <= '0;
            idx   <= '0;
            if (bus.rx_data > 8'(MAX_PAYLOAD)) begin
              error_q <= 1'b1;
              state   <= ST_IDLE;
            end else if (bus.rx_data == 8'd0) begin
              state <= ST_CRC;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            // START_BYTE is plain data here; only the length counts bytes.
            buf_q[idx] <= bus.rx_data;
            crc        <= crc_next;
            idx        <= idx + 4'd1;
            if ({4'd0, idx} == len_q - 8'd1) state <= ST_CRC;
          end
          default: begin
            if (bus.rx_data == crc) begin
              done_q  <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.packet_done  = done_q;
  assign bus.packet_error = error_q;
  assign bus.payload_len  = len_q;
  assign bus.buffer_valid = valid_q;
  assign bus.buf0  = buf_q[0];
  assign bus.buf1  = buf_q[1];
  assign bus.buf2  = buf_q[2];
  assign bus.buf3  = buf_q[3];
  assign bus.buf4  = buf_q[4];
  assign bus.buf5  = buf_q[5];
  assign bus.buf6  = buf_q[6];
  assign bus.buf7  = buf_q[7];
  assign bus.buf8  = buf_q[8];
  assign bus.buf9  = buf_q[9];
  assign bus.buf10 = buf_q[10];
  assign bus.buf11 = buf_q[11];
  assign bus.buf12 = buf_q[12];
  assign bus.buf13 = buf_q[13];
  assign bus.buf14 = buf_q[14];
  assign bus.buf15 = buf_q[15];
endmodule

// File: tb/tb_s3g_packet_rx.sv
// Scoreboarded bench for s3g_packet_rx: frame-level reference model feeds an expectation queue.
module tb_s3g_packet_rx;
  import s3g_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s3g_packet_rx_if bus ();

  s3g_packet_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_done;
    logic [7:0] len;
    logic [7:0] data [16];
  } exp_t;

  exp_t       sb [$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] shadow [16];
  bit         exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_buf(input int i);
    case (i)
      0: return bus.buf0;   1: return bus.buf1;   2: return bus.buf2;   3: return bus.buf3;
      4: return bus.buf4;   5: return bus.buf5;   6: return bus.buf6;   7: return bus.buf7;
      8: return bus.buf8;   9: return bus.buf9;   10: return bus.buf10; 11: return bus.buf11;
      12: return bus.buf12; 13: return bus.buf13; 14: return bus.buf14; default: return bus.buf15;
    endcase
  endfunction

  // Bit-serial LSB-first CRC-8/Maxim over a byte list, starting from zero.
  function automatic logic [7:0] ref_crc(input logic [7:0] q [$]);
    logic [7:0] c;
    logic [7:0] b;
    bit         mix;
    c = 8'h00;
    foreach (q[k]) begin
      b = q[k];
      for (int j = 0; j < 8; j++) begin
        mix = c[0] ^ b[0];
        c   = c >> 1;
        b   = b >> 1;
        if (mix) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    bus.rx_data = $urandom_range(0, 255);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl [$],
                            input logic [7:0] crc_byte, input int gap);
    exp_t e;
    check("valid_before_start", bus.buffer_valid, exp_valid);
    send_byte(START_BYTE, gap);
    exp_valid = 1'b0;
    check("valid_cleared_at_start", bus.buffer_valid, 1'b0);
    e.len = len;
    if (len > 8'd16) begin
      e.is_done = 1'b0;
      e.data    = shadow;
      sb.push_back(e);
      send_byte(len, gap);
    end else begin
      send_byte(len, gap);
      for (int i = 0; i < int'(len); i++) begin
        shadow[i] = pl[i];
        send_byte(pl[i], gap);
      end
      e.is_done = (crc_byte == ref_crc(pl));
      e.data    = shadow;
      sb.push_back(e);
      if (e.is_done) exp_valid = 1'b1;
      send_byte(crc_byte, gap);
    end
    repeat (2) @(posedge clk);
    check("pulse_seen", sb.size(), 0);
  endtask

  // Monitor: every done/error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (bus.packet_done || bus.packet_error)) begin
      check("pulse_exclusive", bus.packet_done & bus.packet_error, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b with no frame pending at %0t",
                 bus.packet_done, bus.packet_error, $time);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_done", bus.packet_done, mon_e.is_done);
        check("payload_len", bus.payload_len, mon_e.len);
        check("buffer_valid", bus.buffer_valid, mon_e.is_done);
        if (mon_e.is_done) begin
          for (int i = 0; i < int'(mon_e.len); i++) check("buf_byte", get_buf(i), mon_e.data[i]);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, bus.packet_done, 1'b0);
    check({tag, "_error"}, bus.packet_error, 1'b0);
    check({tag, "_valid"}, bus.buffer_valid, 1'b0);
    check({tag, "_len"}, bus.payload_len, 8'h00);
    for (int i = 0; i < 16; i++) check({tag, "_buf"}, get_buf(i), 8'h00);
  endtask

  initial begin
    logic [7:0] pl [$];
    logic [7:0] len;
    logic [7:0] crc_b;
    int         gap;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Junk byte, then a frame whose CRC byte is wrong.
    send_byte(8'h0D, 9);
    check("junk_ignored_valid", bus.buffer_valid, 1'b0);
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'd3, pl, 8'hCC, 9);
    check("bad_crc_valid_low", bus.buffer_valid, 1'b0);

    send_frame(8'd3, pl, 8'hD8, 9);
    pl = '{8'h00, 8'h01, 8'h02};
    send_frame(8'd3, pl, 8'h78, 9);
    pl = '{8'h1B, 8'h01, 8'h02};
    send_frame(8'd3, pl, 8'hF3, 9);
    pl = {};
    send_frame(8'h11, pl, 8'h00, 9);
    send_frame(8'd0, pl, 8'h00, 9);
    check("empty_frame_len", bus.payload_len, 8'h00);

    // Reset in the middle of a frame aborts it without any pulse.
    send_byte(START_BYTE, 3);
    send_byte(8'h03, 3);
    send_byte(8'h01, 3);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midframe_reset");
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    exp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'd3, pl, ref_crc(pl), 2);

    // Randomized frames: junk between frames, lengths across the boundary, mixed CRCs.
    for (int f = 0; f < 60; f++) begin
      gap = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        crc_b = $urandom_range(0, 255);
        if (crc_b == START_BYTE) crc_b = 8'h00;
        send_byte(crc_b, gap);
      end
      len = 8'($urandom_range(0, 18));
      pl  = {};
      if (len <= 8'd16) begin
        for (int i = 0; i < int'(len); i++)
          pl.push_back(($urandom_range(0, 7) == 0) ? START_BYTE : 8'($urandom_range(0, 255)));
      end
      crc_b = ($urandom_range(0, 1) == 1) ? ref_crc(pl) : 8'($urandom_range(0, 255));
      send_frame(len, pl, crc_b, gap);
    end

    repeat (10) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
